// File: rtl/fp_addsub_seq.sv
// Multi-cycle single-precision add/subtract: unpack, align, add/sub, normalize, pack.
// A single 1-bit shifter and one mantissa-wide adder are reused across the FSM states.
module fp_addsub_seq #(
  parameter int unsigned EXP_W     = 8,
  parameter int unsigned MAN_W     = 23,
  parameter int unsigned FAR_SHIFT = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   opcode,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow
);

  localparam int unsigned M = MAN_W + 1;
  localparam int unsigned W = EXP_W + MAN_W + 1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] FAR_LIM = EXP_W'(FAR_SHIFT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  state_t           state_q;
  logic             sa_q, sb_q, eff_sub_q, sr_q;
  logic [EXP_W-1:0] ea_q, eb_q, er_q;
  logic [M-1:0]     ma_q, mb_q;
  logic [M:0]       sum_q;
  logic             busy_q, done_q, ovf_q;
  logic [W-1:0]     result_q;

  logic             a_exp_lt;
  logic [EXP_W-1:0] exp_diff;
  logic             mag_a_ge;
  logic [M:0]       sh_in, sh_out;
  logic             sh_left;
  logic [M-1:0]     add_x, add_y;
  logic [M:0]       add_out;

  always_comb begin
    a_exp_lt = ea_q < eb_q;
    exp_diff = a_exp_lt ? (eb_q - ea_q) : (ea_q - eb_q);
    mag_a_ge = ma_q >= mb_q;

    // Shared shifter: right-shifts the smaller mantissa while aligning,
    // right/left-shifts the raw sum while normalizing.
    sh_in   = (state_q == S_ALIGN) ? {1'b0, (a_exp_lt ? ma_q : mb_q)} : sum_q;
    sh_left = (state_q == S_NORM) && !sum_q[M];
    sh_out  = sh_left ? (sh_in << 1) : (sh_in >> 1);

    // Shared adder: subtract is larger + ~smaller + 1; the carry-out is dropped later.
    add_x   = (eff_sub_q && !mag_a_ge) ? mb_q : ma_q;
    add_y   = (eff_sub_q && !mag_a_ge) ? ma_q : mb_q;
    add_out = {1'b0, add_x} + {1'b0, add_y ^ {M{eff_sub_q}}} + {{M{1'b0}}, eff_sub_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      eff_sub_q <= 1'b0;
      sr_q      <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
      er_q      <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      sum_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sa_q      <= a[W-1];
            sb_q      <= b[W-1] ^ opcode;
            eff_sub_q <= a[W-1] ^ b[W-1] ^ opcode;
            ea_q      <= a[W-2:MAN_W];
            eb_q      <= b[W-2:MAN_W];
            ma_q      <= (a[W-2:MAN_W] != '0) ? {1'b1, a[MAN_W-1:0]} : '0;
            mb_q      <= (b[W-2:MAN_W] != '0) ? {1'b1, b[MAN_W-1:0]} : '0;
            busy_q    <= 1'b1;
            state_q   <= S_ALIGN;
          end
        end

        S_ALIGN: begin
          if (ea_q == eb_q) begin
            state_q <= S_ADD;
          end else if (exp_diff > FAR_LIM) begin
            if (a_exp_lt) begin
              ma_q <= '0;
              ea_q <= eb_q;
            end else begin
              mb_q <= '0;
              eb_q <= ea_q;
            end
          end else if (a_exp_lt) begin
            ma_q <= sh_out[M-1:0];
            ea_q <= ea_q + EXP_ONE;
          end else begin
            mb_q <= sh_out[M-1:0];
            eb_q <= eb_q + EXP_ONE;
          end
        end

        S_ADD: begin
          sum_q   <= eff_sub_q ? {1'b0, add_out[M-1:0]} : add_out;
          sr_q    <= (eff_sub_q && !mag_a_ge) ? sb_q : sa_q;
          er_q    <= ea_q;
          state_q <= S_NORM;
        end

        S_NORM: begin
          if (sum_q == '0) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (sum_q[M]) begin
            sum_q <= sh_out;
            er_q  <= er_q + EXP_ONE;
          end else if (er_q == EXP_MAX) begin
            result_q <= {sr_q, EXP_MAX, {MAN_W{1'b0}}};
            ovf_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (sum_q[M-1]) begin
            result_q <= {sr_q, er_q, sum_q[MAN_W-1:0]};
            ovf_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (er_q == EXP_ONE) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            sum_q <= sh_out;
            er_q  <= er_q - EXP_ONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule
